// File: rtl/led_pulser_mc.sv
// led_pulser_mc: multi-channel active-low LED pulse/dim engine with period-aligned config apply
//   clk, reset          : system clock, synchronous active-high reset
//   ch_gate             : per-channel enable, 0 forces that LED off
//   cfg_valid/cfg_ready : config write handshake (cfg_ready is combinational)
//   cfg_ch/mode/duty    : target channel, mode (off/solid/pulse/breathe), brightness
//   led_n               : registered active-low LED drive
//   tick, period_start  : base tick strobe and period-wrap strobe
module led_pulser_mc #(
   parameter int CHANNELS     = 2,
   parameter int PRESCALE     = 240,
   parameter int PERIOD_TICKS = 100000,
   parameter int ON_TICKS     = 15000,
   parameter int PWM_BITS     = 7
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [CHANNELS-1:0] ch_gate,
   input  logic                cfg_valid,
   output logic                cfg_ready,
   input  logic [2:0]          cfg_ch,
   input  logic [1:0]          cfg_mode,
   input  logic [PWM_BITS-1:0] cfg_duty,
   output logic [CHANNELS-1:0] led_n,
   output logic                tick,
   output logic                period_start
);
   localparam int PRE_W = $clog2(PRESCALE);
   localparam int PER_W = $clog2(PERIOD_TICKS);
   localparam logic [1:0] M_SOLID   = 2'b01;
   localparam logic [1:0] M_PULSE   = 2'b10;
   localparam logic [1:0] M_BREATHE = 2'b11;

   logic [PRE_W-1:0]                   pre_cnt_q, pre_cnt_d;
   logic [PER_W-1:0]                   period_cnt_q, period_cnt_d;
   logic [PWM_BITS-1:0]                pwm_cnt_q, pwm_cnt_d;
   logic                               tick_q, tick_d;
   logic [CHANNELS-1:0][1:0]           act_mode_q, act_mode_d, sh_mode_q, sh_mode_d;
   logic [CHANNELS-1:0][PWM_BITS-1:0]  act_duty_q, act_duty_d, sh_duty_q, sh_duty_d;
   logic [CHANNELS-1:0][PWM_BITS-1:0]  level_q, level_d;
   logic [CHANNELS-1:0]                dir_up_q, dir_up_d;
   logic [CHANNELS-1:0]                pending_q, pending_d;
   logic [CHANNELS-1:0]                led_n_q, led_n_d;
   logic [CHANNELS-1:0]                apply_v, wr_v, lit_v, up_hit_v;
   logic [7:0]                         pend_ext;
   logic                               pre_last, per_last, pwm_wrap, in_window, ch_ok, cfg_take;

   always_comb begin
      pre_last     = pre_cnt_q == PRE_W'(PRESCALE - 1);
      per_last     = period_cnt_q == PER_W'(PERIOD_TICKS - 1);
      pre_cnt_d    = pre_last ? '0 : pre_cnt_q + 1'b1;
      tick_d       = pre_last;
      period_start = tick_q & per_last;
      period_cnt_d = !tick_q ? period_cnt_q : (per_last ? '0 : period_cnt_q + 1'b1);
      pwm_cnt_d    = pwm_cnt_q + PWM_BITS'(tick_q);
      pwm_wrap     = tick_q & (&pwm_cnt_q);
      in_window    = period_cnt_q >= PER_W'(PERIOD_TICKS - ON_TICKS);
      // widen pending so any 3-bit channel index is a legal select
      pend_ext     = 8'(pending_q);
      ch_ok        = 32'(cfg_ch) < CHANNELS;
      cfg_ready    = !ch_ok | !pend_ext[cfg_ch];
      cfg_take     = cfg_valid & cfg_ready & ch_ok;
      apply_v      = {CHANNELS{period_start}} & pending_q;
      wr_v         = '0;
      lit_v        = '0;
      up_hit_v     = '0;
      act_mode_d   = act_mode_q;
      act_duty_d   = act_duty_q;
      sh_mode_d    = sh_mode_q;
      sh_duty_d    = sh_duty_q;
      pending_d    = pending_q;
      level_d      = level_q;
      dir_up_d     = dir_up_q;
      led_n_d      = led_n_q;
      for (int i = 0; i < CHANNELS; i++) begin
         wr_v[i]       = cfg_take & (cfg_ch == 3'(i));
         sh_mode_d[i]  = wr_v[i] ? cfg_mode : sh_mode_q[i];
         sh_duty_d[i]  = wr_v[i] ? cfg_duty : sh_duty_q[i];
         // a write can only land on a non-pending channel, so it never collides with apply
         pending_d[i]  = wr_v[i] | (pending_q[i] & !apply_v[i]);
         act_mode_d[i] = apply_v[i] ? sh_mode_q[i] : act_mode_q[i];
         act_duty_d[i] = apply_v[i] ? sh_duty_q[i] : act_duty_q[i];
         // rising edge reaches (or already sits at) duty: turn around on this wrap
         up_hit_v[i]   = ({1'b0, level_q[i]} + 1'b1) >= {1'b0, act_duty_q[i]};
         level_d[i]    = apply_v[i] ? '0 :
                         !pwm_wrap ? level_q[i] :
                         dir_up_q[i] ? (level_q[i] < act_duty_q[i] ? level_q[i] + 1'b1 : level_q[i]) :
                         (level_q[i] != '0 ? level_q[i] - 1'b1 : level_q[i]);
         dir_up_d[i]   = apply_v[i] ? 1'b1 :
                         !pwm_wrap ? dir_up_q[i] :
                         dir_up_q[i] ? !up_hit_v[i] : (level_q[i] <= PWM_BITS'(1));
         lit_v[i]      = (act_mode_q[i] == M_SOLID & pwm_cnt_q < act_duty_q[i]) |
                         (act_mode_q[i] == M_PULSE & pwm_cnt_q < act_duty_q[i] & in_window) |
                         (act_mode_q[i] == M_BREATHE & pwm_cnt_q < level_q[i]);
         led_n_d[i]    = !(ch_gate[i] & lit_v[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pre_cnt_q    <= '0;
         period_cnt_q <= '0;
         pwm_cnt_q    <= '0;
         tick_q       <= 1'b0;
         act_mode_q   <= '0;
         act_duty_q   <= '0;
         sh_mode_q    <= '0;
         sh_duty_q    <= '0;
         pending_q    <= '0;
         level_q      <= '0;
         dir_up_q     <= '1;
         led_n_q      <= '1;
      end else begin
         pre_cnt_q    <= pre_cnt_d;
         period_cnt_q <= period_cnt_d;
         pwm_cnt_q    <= pwm_cnt_d;
         tick_q       <= tick_d;
         act_mode_q   <= act_mode_d;
         act_duty_q   <= act_duty_d;
         sh_mode_q    <= sh_mode_d;
         sh_duty_q    <= sh_duty_d;
         pending_q    <= pending_d;
         level_q      <= level_d;
         dir_up_q     <= dir_up_d;
         led_n_q      <= led_n_d;
      end
   end

   assign led_n = led_n_q;
   assign tick  = tick_q;
endmodule

// File: tb/tb_led_pulser_mc.sv
// tb_led_pulser_mc: scoreboard bench for led_pulser_mc against an arithmetic reference model
module tb_led_pulser_mc;
   localparam int CH = 2;
   localparam int P  = 4;
   localparam int PT = 20;
   localparam int ON = 5;
   localparam int B  = 3;
   localparam int PM = 1 << B;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [CH-1:0] ch_gate = '0;
   logic          cfg_valid = 1'b0;
   logic          cfg_ready;
   logic [2:0]    cfg_ch = '0;
   logic [1:0]    cfg_mode = '0;
   logic [B-1:0]  cfg_duty = '0;
   logic [CH-1:0] led_n;
   logic          tick, period_start;

   led_pulser_mc #(.CHANNELS(CH), .PRESCALE(P), .PERIOD_TICKS(PT), .ON_TICKS(ON), .PWM_BITS(B)) dut (
      .clk(clk), .reset(reset), .ch_gate(ch_gate), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_ch(cfg_ch), .cfg_mode(cfg_mode), .cfg_duty(cfg_duty), .led_n(led_n), .tick(tick),
      .period_start(period_start)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [CH-1:0] led;
      logic          tk;
      logic          ps;
      logic          rdy;
   } exp_t;
   exp_t q[$];

   int n_checks = 0;
   int n_fail = 0;

   // reference state: edges since reset plus per-channel config and breathe wrap count
   bit          mvalid = 0;
   int unsigned n = 0;
   bit [1:0]    m_act_mode[CH], m_sh_mode[CH];
   int          m_act_duty[CH], m_sh_duty[CH], m_wraps[CH];
   bit          m_pend[CH];
   bit [CH-1:0] m_led = '1;

   function automatic int tri_level(input int k, input int d);
      int pos;
      if (d == 0) return 0;
      pos = k % (2 * d);
      return (pos <= d) ? pos : 2 * d - pos;
   endfunction

   always @(negedge clk) begin
      int td, pc, pw, idx, lvl;
      bit tk, ps, rdy, lit;
      exp_t e;
      td = (n > 0) ? int'((n - 1) / P) : 0;
      tk = (n > 0) && (n % P == 0);
      pc = td % PT;
      pw = td % PM;
      ps = tk && (pc == PT - 1);
      idx = int'(cfg_ch);
      rdy = (idx >= CH) ? 1'b1 : !m_pend[idx];
      if (mvalid) begin
         e.led = m_led; e.tk = tk; e.ps = ps; e.rdy = rdy;
         q.push_back(e);
      end
      if (reset) begin
         mvalid = 1; n = 0; m_led = '1;
         for (int c = 0; c < CH; c++) begin
            m_act_mode[c] = 0; m_sh_mode[c] = 0; m_act_duty[c] = 0; m_sh_duty[c] = 0;
            m_pend[c] = 0; m_wraps[c] = 0;
         end
      end else if (mvalid) begin
         for (int c = 0; c < CH; c++) begin
            lvl = tri_level(m_wraps[c], m_act_duty[c]);
            case (m_act_mode[c])
               2'b01:   lit = pw < m_act_duty[c];
               2'b10:   lit = (pw < m_act_duty[c]) && (pc >= PT - ON);
               2'b11:   lit = pw < lvl;
               default: lit = 0;
            endcase
            m_led[c] = !(ch_gate[c] && lit);
            if (ps && m_pend[c]) begin
               m_act_mode[c] = m_sh_mode[c]; m_act_duty[c] = m_sh_duty[c];
               m_pend[c] = 0; m_wraps[c] = 0;
            end else if (tk && pw == PM - 1) m_wraps[c]++;
         end
         if (cfg_valid && rdy && idx < CH) begin
            m_sh_mode[idx] = cfg_mode; m_sh_duty[idx] = int'(cfg_duty); m_pend[idx] = 1;
         end
         n++;
      end
   end

   task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, got, want, $time);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      #1;
      if (q.size() > 0) begin
         e = q.pop_front();
         chk("led_n", 8'(led_n), 8'(e.led));
         chk("tick", 8'(tick), 8'(e.tk));
         chk("period_start", 8'(period_start), 8'(e.ps));
         chk("cfg_ready", 8'(cfg_ready), 8'(e.rdy));
      end
   end

   task automatic idle(input int k);
      repeat (k) begin @(posedge clk); #1; end
   endtask

   task automatic wr(input int ch, input int mode, input int duty);
      @(posedge clk); #1;
      cfg_valid = 1'b1; cfg_ch = 3'(ch); cfg_mode = 2'(mode); cfg_duty = B'(duty);
      @(posedge clk); #1;
      cfg_valid = 1'b0;
   endtask

   initial begin
      idle(3);
      reset = 1'b0;
      idle(200);
      ch_gate = 2'b11;
      idle(9);
      wr(0, 1, 3);
      idle(250);
      wr(1, 2, 7);
      idle(250);
      wr(0, 3, 2);
      idle(700);
      wr(0, 1, 5);
      wr(0, 0, 1);
      wr(1, 3, 4);
      wr(5, 2, 6);
      cfg_ch = 3'd0;
      idle(200);
      wr(0, 2, 6);
      idle(10);
      @(posedge clk); #1; reset = 1'b1;
      @(posedge clk); #1; reset = 1'b0;
      idle(200);
      for (int i = 0; i < 2500; i++) begin
         @(posedge clk); #1;
         cfg_valid = 1'b0;
         if ($urandom_range(0, 15) == 0) ch_gate = CH'($urandom);
         if ($urandom_range(0, 9) == 0) begin
            cfg_valid = 1'b1;
            cfg_ch = 3'($urandom_range(0, 7));
            cfg_mode = 2'($urandom);
            cfg_duty = B'($urandom);
         end else if ($urandom_range(0, 3) == 0) cfg_ch = 3'($urandom_range(0, 7));
         reset = ($urandom_range(0, 499) == 0);
      end
      @(posedge clk); #1; cfg_valid = 1'b0; reset = 1'b0;
      idle(5);
      for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
      n_checks++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d entries left want 0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
